// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetchState_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] LINK_OFFSET      = 32'd4;
  localparam int          WORD_SHIFT       = 2;

endpackage

// File: rtl/instruction_fetch_unit_next_pc_logic.sv
// Next-PC resolution for the held instruction: jr > j/jal > taken branch > pc+4.
module next_pc_logic
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] iPc,
  input  logic [25:0] iInstrIndex,
  input  logic        iBranch,
  input  logic        iNBranch,
  input  logic        iZero,
  input  logic        iJmp,
  input  logic        iJal,
  input  logic        iJr,
  input  logic [31:0] iImmExtended,
  input  logic [31:0] iRegRs,
  output logic [31:0] oNextPc,
  output logic        oMisaligned
);

  logic [31:0] pc4;
  logic        branchTaken;

  assign pc4         = iPc + LINK_OFFSET;
  assign branchTaken = (iBranch & iZero) | (iNBranch & ~iZero);

  // Priority mux; beq and bne together simply fall through the same taken formula.
  always_comb begin
    oNextPc = pc4;
    if (iJr) begin
      oNextPc = iRegRs;
    end else if (iJmp | iJal) begin
      oNextPc = {pc4[31:28], iInstrIndex, 2'b00};
    end else if (branchTaken) begin
      oNextPc = pc4 + (iImmExtended << WORD_SHIFT);
    end
  end

  assign oMisaligned = |oNextPc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over req/ack and holds
// the fetched instruction until the downstream stage retires it.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// REQ   | request outstanding at oPc, waiting for ack
// HOLD  | instruction valid, waiting for iStall=0 to retire
// FAULT | misaligned target taken, parked until reset
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_WIDTH = 14
) (
  input  logic                       iCpuClock,
  input  logic                       iCpuReset,
  input  logic                       iStall,
  input  logic                       iBranch,
  input  logic                       iNBranch,
  input  logic                       iZero,
  input  logic                       iJmp,
  input  logic                       iJal,
  input  logic                       iJr,
  input  logic [31:0]                iImmExtended,
  input  logic [31:0]                iRegRs,
  output logic                       oImemReq,
  output logic [IMEM_ADDR_WIDTH-1:0] oImemAddr,
  input  logic                       iImemAck,
  input  logic [31:0]                iImemData,
  output logic [31:0]                oInstruction,
  output logic                       oInstructionValid,
  output logic [31:0]                oPc,
  output logic [31:0]                oPcPlus4,
  output logic                       oFetchFault,
  output logic [31:0]                oRetiredCount
);

  fetchState_t state, stateNext;
  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] retiredReg;
  logic [31:0] nextPc;
  logic        misaligned;
  logic        accept;
  logic        retire;

  next_pc_logic uNextPc (
    .iPc          (pcReg),
    .iInstrIndex  (instrReg[25:0]),
    .iBranch      (iBranch),
    .iNBranch     (iNBranch),
    .iZero        (iZero),
    .iJmp         (iJmp),
    .iJal         (iJal),
    .iJr          (iJr),
    .iImmExtended (iImmExtended),
    .iRegRs       (iRegRs),
    .oNextPc      (nextPc),
    .oMisaligned  (misaligned)
  );

  // Next-state decode plus the accept/retire strobes for the datapath.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (iImemAck) begin
          accept    = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (!iStall) begin
          retire    = 1'b1;
          stateNext = misaligned ? FAULT : REQ;
        end
      end
      FAULT:   stateNext = FAULT;
      default: stateNext = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // PC, held instruction and retire counter; a faulting target still lands in the PC.
  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      pcReg      <= RESET_PC;
      instrReg   <= 32'h0;
      retiredReg <= 32'h0;
    end else begin
      if (accept) begin
        instrReg <= iImemData;
      end
      if (retire) begin
        pcReg      <= nextPc;
        retiredReg <= retiredReg + 32'd1;
      end
    end
  end

  // Addresses past the memory simply wrap by truncation.
  assign oImemAddr         = pcReg[IMEM_ADDR_WIDTH+1:2];
  assign oImemReq          = (state == REQ);
  assign oInstructionValid = (state == HOLD);
  assign oFetchFault       = (state == FAULT);
  assign oInstruction      = instrReg;
  assign oPc               = pcReg;
  assign oPcPlus4          = pcReg + LINK_OFFSET;
  assign oRetiredCount     = retiredReg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit: handshake, stall, next-PC table, fault, reset.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rstN;
  logic        stall, branch, nBranch, zero, jmp, jal, jr;
  logic [31:0] imm, regRs;
  logic        imemReq;
  logic [13:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic        instructionValid;
  logic [31:0] pc, pcPlus4;
  logic        fetchFault;
  logic [31:0] retiredCount;

  int checks   = 0;
  int failures = 0;
  logic [31:0] expCount;

  instruction_fetch_unit dut (
    .iCpuClock         (clk),
    .iCpuReset         (rstN),
    .iStall            (stall),
    .iBranch           (branch),
    .iNBranch          (nBranch),
    .iZero             (zero),
    .iJmp              (jmp),
    .iJal              (jal),
    .iJr               (jr),
    .iImmExtended      (imm),
    .iRegRs            (regRs),
    .oImemReq          (imemReq),
    .oImemAddr         (imemAddr),
    .iImemAck          (imemAck),
    .iImemData         (imemData),
    .oInstruction      (instruction),
    .oInstructionValid (instructionValid),
    .oPc               (pc),
    .oPcPlus4          (pcPlus4),
    .oFetchFault       (fetchFault),
    .oRetiredCount     (retiredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] startPc;
    logic [31:0] instr;
    logic        vJr, vJal, vJmp, vBr, vNbr, vZero;
    logic [31:0] vImm, vRs, expPc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCtrl();
    stall = 0; branch = 0; nBranch = 0; zero = 0; jmp = 0; jal = 0; jr = 0;
    imm = 0; regRs = 0;
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_req"},   {31'b0, imemReq}, 32'd0);
    check({tag, "_valid"}, {31'b0, instructionValid}, 32'd0);
    check({tag, "_pc"},    pc, 32'h0);
    check({tag, "_instr"}, instruction, 32'h0);
    check({tag, "_fault"}, {31'b0, fetchFault}, 32'd0);
    check({tag, "_count"}, retiredCount, 32'h0);
  endtask

  initial begin
    rstN = 0; imemAck = 0; imemData = 0; expCount = 0;
    clearCtrl();
    #12;
    checkResetValues("reset");

    // Basic fetch with ack held high
    imemAck = 1; imemData = 32'hAAAA_5555;
    rstN = 1;
    step();
    check("idle_to_req", {31'b0, imemReq}, 32'd1);
    check("first_addr", {18'b0, imemAddr}, 32'd0);
    check("no_valid_in_req", {31'b0, instructionValid}, 32'd0);
    step();
    check("first_valid", {31'b0, instructionValid}, 32'd1);
    check("first_instr", instruction, 32'hAAAA_5555);
    check("first_pc", pc, 32'h0);
    check("first_pc4", pcPlus4, 32'h4);
    step();
    expCount++;
    imemAck = 0;
    check("retire_req", {31'b0, imemReq}, 32'd1);
    check("retire_addr", {18'b0, imemAddr}, 32'd1);
    check("retire_count", retiredCount, expCount);
    check("retire_valid", {31'b0, instructionValid}, 32'd0);

    // Ack after three waiting cycles
    imemData = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", {31'b0, imemReq}, 32'd1);
      check("wait_addr", {18'b0, imemAddr}, 32'd1);
      check("wait_valid", {31'b0, instructionValid}, 32'd0);
    end
    imemAck = 1; stall = 1;
    step();
    imemAck = 0; imemData = 32'hFFFF_FFFF;
    check("late_valid", {31'b0, instructionValid}, 32'd1);
    check("late_instr", instruction, 32'h1234_5678);

    // Stall for five cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'b0, instructionValid}, 32'd1);
      check("stall_instr", instruction, 32'h1234_5678);
      check("stall_pc", pc, 32'h4);
      check("stall_count", retiredCount, expCount);
    end
    stall = 0;
    step();
    expCount++;
    check("unstall_pc", pc, 32'h8);
    check("unstall_count", retiredCount, expCount);
    check("unstall_req", {31'b0, imemReq}, 32'd1);

    // Next-PC vector table
    vecs[0] = '{"beq_taken",   32'h0000_0010, 32'h0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h4,         32'h0,   32'h0000_0024};
    vecs[1] = '{"beq_not",     32'h0000_0010, 32'h0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h4,         32'h0,   32'h0000_0014};
    vecs[2] = '{"bne_back",    32'h0000_0010, 32'h0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'hFFFF_FFFF, 32'h0,   32'h0000_0010};
    vecs[3] = '{"jal",         32'h0040_0008, 32'h0010_0004, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0040_0010};
    vecs[4] = '{"jr_over_jal", 32'h0000_0010, 32'h0010_0004, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h100, 32'h0000_0100};
    vecs[5] = '{"j_high",      32'hF000_0000, 32'h03FF_FFFF, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC};
    vecs[6] = '{"bne_not",     32'h0000_0020, 32'h0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h8,         32'h0,   32'h0000_0024};
    vecs[7] = '{"beq_bne",     32'h0000_0020, 32'h0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 32'h2,         32'h0,   32'h0000_002C};
    vecs[8] = '{"wrap_addr",   32'h0001_0000, 32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,         32'h0,   32'h0001_0004};

    for (int v = 0; v < 9; v++) begin
      // Park PC at the vector's start address via a jr retire
      imemAck = 1; imemData = 32'h0;
      step();
      imemAck = 0;
      jr = 1; regRs = vecs[v].startPc;
      step();
      expCount++;
      clearCtrl();
      check({vecs[v].name, "_load_pc"}, pc, vecs[v].startPc);
      check({vecs[v].name, "_load_addr"}, {18'b0, imemAddr}, {18'b0, vecs[v].startPc[15:2]});
      imemAck = 1; imemData = vecs[v].instr;
      step();
      imemAck = 0;
      jr = vecs[v].vJr; jal = vecs[v].vJal; jmp = vecs[v].vJmp;
      branch = vecs[v].vBr; nBranch = vecs[v].vNbr; zero = vecs[v].vZero;
      imm = vecs[v].vImm; regRs = vecs[v].vRs;
      #1;
      check({vecs[v].name, "_pc4"}, pcPlus4, vecs[v].startPc + 32'd4);
      step();
      expCount++;
      clearCtrl();
      check({vecs[v].name, "_next_pc"}, pc, vecs[v].expPc);
      check({vecs[v].name, "_count"}, retiredCount, expCount);
      check({vecs[v].name, "_req"}, {31'b0, imemReq}, 32'd1);
      check({vecs[v].name, "_nofault"}, {31'b0, fetchFault}, 32'd0);
    end

    // Misaligned jr target parks in FAULT
    imemAck = 1; imemData = 32'h0;
    step();
    imemAck = 0;
    jr = 1; regRs = 32'h0000_1002;
    step();
    clearCtrl();
    check("fault_flag", {31'b0, fetchFault}, 32'd1);
    check("fault_pc", pc, 32'h0000_1002);
    check("fault_req", {31'b0, imemReq}, 32'd0);
    check("fault_valid", {31'b0, instructionValid}, 32'd0);
    imemAck = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("fault_sticky", {31'b0, fetchFault}, 32'd1);
      check("fault_no_req", {31'b0, imemReq}, 32'd0);
      check("fault_hold_pc", pc, 32'h0000_1002);
    end
    imemAck = 0;

    // Reset out of FAULT, then reset mid-REQ with a late ack
    rstN = 0;
    #1;
    checkResetValues("reset_fault");
    rstN = 1;
    step();
    check("rst2_req", {31'b0, imemReq}, 32'd1);
    step();
    check("rst2_still_req", {31'b0, imemReq}, 32'd1);
    rstN = 0;
    #1;
    checkResetValues("reset_midreq");
    imemAck = 1; imemData = 32'hDEAD_BEEF;
    #1;
    rstN = 1;
    step();
    check("late_ack_ignored_valid", {31'b0, instructionValid}, 32'd0);
    check("late_ack_ignored_instr", instruction, 32'h0);
    check("late_ack_req", {31'b0, imemReq}, 32'd1);
    step();
    imemAck = 0;
    check("post_reset_valid", {31'b0, instructionValid}, 32'd1);
    check("post_reset_instr", instruction, 32'hDEAD_BEEF);
    check("post_reset_pc", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
